// File: rtl/axis_apb_ethernet_rx_buffer_if.sv
// Bus bundle for the Ethernet RX buffer: MAC-side AXI-Stream receive
// channel plus the software-side APB completer port.
interface axis_apb_ethernet_rx_buffer_if #(
    parameter int ADDR_WIDTH = 16
) ();
    logic                  axis_tvalid;
    logic                  axis_tready;
    logic [31:0]           axis_tdata;
    logic [3:0]            axis_tstrb;
    logic                  axis_tlast;
    logic                  axis_tuser;

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [31:0]           pwdata;
    logic                  pready;
    logic [31:0]           prdata;
    logic                  pslverr;

    modport slave (
        input  axis_tvalid, axis_tdata, axis_tstrb, axis_tlast, axis_tuser,
        input  psel, penable, pwrite, paddr, pwdata,
        output axis_tready, pready, prdata, pslverr
    );

    modport master (
        output axis_tvalid, axis_tdata, axis_tstrb, axis_tlast, axis_tuser,
        output psel, penable, pwrite, paddr, pwdata,
        input  axis_tready, pready, prdata, pslverr
    );
endinterface

// File: rtl/axis_apb_ethernet_rx_buffer.sv
// Ethernet RX buffer: stores good frames from an AXI-Stream MAC into a word
// FIFO with a parallel frame-length FIFO, rolls back errored/overflowing
// frames, and lets software drain frames word by word over APB.
module axis_apb_ethernet_rx_buffer #(
    parameter int DEPTH_WORDS = 1024,
    parameter int MAX_FRAMES  = 32,
    parameter int ADDR_WIDTH  = 16
) (
    input logic                          clk,
    input logic                          rst,
    axis_apb_ethernet_rx_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(MAX_FRAMES);
    localparam logic [PW-1:0] DATA_FULL = PW'(DEPTH_WORDS);
    localparam logic [LW:0]   LEN_FULL  = (LW + 1)'(MAX_FRAMES);
    localparam logic [ADDR_WIDTH-1:0] A_STAT   = ADDR_WIDTH'(32'h00);
    localparam logic [ADDR_WIDTH-1:0] A_LENGTH = ADDR_WIDTH'(32'h20);
    localparam logic [ADDR_WIDTH-1:0] A_RXWORD = ADDR_WIDTH'(32'h40);
    localparam logic [ADDR_WIDTH-1:0] A_POP    = ADDR_WIDTH'(32'h60);
    localparam logic [ADDR_WIDTH-1:0] A_DROP   = ADDR_WIDTH'(32'h80);

    // Number of valid byte lanes in a beat.
    function automatic logic [2:0] popcount4(input logic [3:0] s);
        return {2'b00, s[0]} + {2'b00, s[1]} + {2'b00, s[2]} + {2'b00, s[3]};
    endfunction

    logic [31:0]   r_mem    [DEPTH_WORDS];
    logic [10:0]   r_lf_mem [MAX_FRAMES];
    logic [PW-1:0] r_wr_ptr, r_commit_ptr, r_rd_ptr, r_words_left;
    logic [LW:0]   r_lf_wr, r_lf_rd;
    logic [11:0]   r_frame_bytes;
    logic          r_bad, r_ovf, r_pf_valid, r_head_loaded;
    logic [31:0]   r_pf_data;
    logic [15:0]   r_drop_cnt;

    logic [LW:0]   w_lf_count;
    logic          w_lf_empty, w_lf_full, w_frame_avail, w_fetch;
    logic [10:0]   w_head_len;
    logic [PW-1:0] w_head_words, w_rd_ptr_nxt, w_wr_ptr_post;
    logic          w_access, w_rx_read, w_pop_wr, w_clr, w_lf_pop;
    logic          w_beat, w_end, w_need_store, w_ovf_data, w_ovf_len, w_too_long;
    logic          w_store, w_frame_ok, w_commit, w_drop;
    logic [11:0]   w_bytes_nxt;
    logic [31:0]   w_store_word, w_prdata;
    logic          w_pslverr;
    logic          w_unused;

    // ---------------- read-side status ----------------
    assign w_lf_count    = r_lf_wr - r_lf_rd;
    assign w_lf_empty    = (w_lf_count == '0);
    assign w_head_len    = r_lf_mem[r_lf_rd[LW-1:0]];
    assign w_head_words  = PW'(({1'b0, w_head_len} + 12'd3) >> 2);
    assign w_frame_avail = !w_lf_empty && r_pf_valid;
    // Refill the prefetch only when a committed frame is at the head.
    assign w_fetch       = !r_pf_valid && !w_lf_empty;

    // ---------------- APB decode ----------------
    assign w_access  = bus.psel && bus.penable;
    assign w_rx_read = w_access && !bus.pwrite && (bus.paddr == A_RXWORD) && w_frame_avail;
    assign w_pop_wr  = w_access && bus.pwrite && (bus.paddr == A_POP) && w_frame_avail;
    assign w_clr     = w_access && bus.pwrite && (bus.paddr == A_DROP);
    assign w_lf_pop  = (w_rx_read && (r_words_left == PW'(1))) || w_pop_wr;
    assign w_unused  = ^bus.pwdata;

    // Next read pointer; the write side's full check sees it so a same-cycle pop frees space.
    always_comb begin
        w_rd_ptr_nxt = r_rd_ptr;
        if (w_rx_read) begin
            w_rd_ptr_nxt = r_rd_ptr + PW'(1);
        end else if (w_pop_wr) begin
            w_rd_ptr_nxt = r_rd_ptr + r_words_left;
        end else begin
            w_rd_ptr_nxt = r_rd_ptr;
        end
    end

    // ---------------- write side ----------------
    assign w_beat        = bus.axis_tvalid && !rst;
    assign w_end         = w_beat && bus.axis_tlast;
    assign w_bytes_nxt   = r_frame_bytes + {9'b0, popcount4(bus.axis_tstrb)};
    assign w_need_store  = w_beat && !r_bad && (bus.axis_tstrb != 4'h0);
    assign w_ovf_data    = w_need_store && ((r_wr_ptr - w_rd_ptr_nxt) == DATA_FULL);
    assign w_too_long    = w_beat && !r_bad && (w_bytes_nxt > 12'd2047);
    assign w_store       = w_need_store && !w_ovf_data && !w_too_long;
    assign w_lf_full     = (w_lf_count == LEN_FULL) && !w_lf_pop;
    assign w_ovf_len     = w_end && !r_bad && w_lf_full;
    assign w_wr_ptr_post = r_wr_ptr + {{AW{1'b0}}, w_store};
    assign w_frame_ok    = !r_bad && !w_ovf_data && !w_too_long && !w_lf_full &&
                           !bus.axis_tuser && (w_bytes_nxt != 12'd0);
    assign w_commit      = w_end && w_frame_ok;
    assign w_drop        = w_end && !w_frame_ok;
    assign w_store_word  = bus.axis_tdata & {{8{bus.axis_tstrb[3]}}, {8{bus.axis_tstrb[2]}},
                                             {8{bus.axis_tstrb[1]}}, {8{bus.axis_tstrb[0]}}};

    // Data/length storage and the registered prefetch read port (block-RAM style, no reset).
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_store_word;
        end
        if (w_commit) begin
            r_lf_mem[r_lf_wr[LW-1:0]] <= w_bytes_nxt[10:0];
        end
        if (w_fetch) begin
            r_pf_data <= r_mem[r_rd_ptr[AW-1:0]];
        end
    end

    // Frame assembly: advance, commit or roll back the write pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_commit_ptr  <= '0;
            r_lf_wr       <= '0;
            r_frame_bytes <= 12'd0;
            r_bad         <= 1'b0;
        end else if (w_end) begin
            r_frame_bytes <= 12'd0;
            r_bad         <= 1'b0;
            if (w_commit) begin
                r_wr_ptr     <= w_wr_ptr_post;
                r_commit_ptr <= w_wr_ptr_post;
                r_lf_wr      <= r_lf_wr + (LW + 1)'(1);
            end else begin
                r_wr_ptr <= r_commit_ptr;
            end
        end else if (w_beat) begin
            r_wr_ptr <= w_wr_ptr_post;
            if (!r_bad) begin
                r_frame_bytes <= w_bytes_nxt;
            end
            if (w_ovf_data || w_too_long) begin
                r_bad <= 1'b1;
            end
        end
    end

    // Drop counter (saturating) and sticky overflow flag; an APB write clears both.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= 16'd0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_clr) begin
                r_drop_cnt <= 16'd0;
            end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            if (w_ovf_data || w_ovf_len) begin
                r_ovf <= 1'b1;
            end else if (w_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Head-frame tracking: read pointer, words remaining, length FIFO pop, prefetch valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr      <= '0;
            r_lf_rd       <= '0;
            r_words_left  <= '0;
            r_head_loaded <= 1'b0;
            r_pf_valid    <= 1'b0;
        end else begin
            r_rd_ptr <= w_rd_ptr_nxt;
            if (w_lf_pop) begin
                r_lf_rd       <= r_lf_rd + (LW + 1)'(1);
                r_head_loaded <= 1'b0;
            end else if (w_rx_read) begin
                r_words_left <= r_words_left - PW'(1);
            end else if (!r_head_loaded && !w_lf_empty) begin
                r_words_left  <= w_head_words;
                r_head_loaded <= 1'b1;
            end
            if (w_rx_read || w_pop_wr) begin
                r_pf_valid <= 1'b0;
            end else if (w_fetch) begin
                r_pf_valid <= 1'b1;
            end
        end
    end

    // APB read mux and error decode; zero-wait, so this is combinational in the access phase.
    always_comb begin
        w_prdata  = 32'h0;
        w_pslverr = 1'b0;
        if (w_access) begin
            case (bus.paddr)
                A_STAT:   if (bus.pwrite) w_pslverr = 1'b1;
                          else            w_prdata  = {30'h0, r_ovf, w_frame_avail};
                A_LENGTH: if (bus.pwrite) w_pslverr = 1'b1;
                          else            w_prdata  = w_frame_avail ? {21'h0, w_head_len} : 32'h0;
                A_RXWORD: if (bus.pwrite || !w_frame_avail) w_pslverr = 1'b1;
                          else                              w_prdata  = r_pf_data;
                A_POP:    if (bus.pwrite) w_pslverr = 1'b0;
                          else            w_pslverr = 1'b1;
                A_DROP:   if (bus.pwrite) w_prdata  = 32'h0;
                          else            w_prdata  = {16'h0, r_drop_cnt};
                default:  w_pslverr = 1'b1;
            endcase
        end else begin
            w_prdata  = 32'h0;
            w_pslverr = 1'b0;
        end
    end

    assign bus.pready      = w_access;
    assign bus.prdata      = w_prdata;
    assign bus.pslverr     = w_pslverr;
    assign bus.axis_tready = ~rst;
endmodule

// File: tb/tb_axis_apb_ethernet_rx_buffer.sv
// Self-checking bench for axis_apb_ethernet_rx_buffer: directed and random
// frames checked against a frame-level queue model of the buffer.
module tb_axis_apb_ethernet_rx_buffer;
    localparam logic [15:0] A_STAT = 16'h0000, A_LEN = 16'h0020, A_RX = 16'h0040;
    localparam logic [15:0] A_POP  = 16'h0060, A_DROP = 16'h0080;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axis_apb_ethernet_rx_buffer_if #(.ADDR_WIDTH(16)) bus ();

    axis_apb_ethernet_rx_buffer #(.DEPTH_WORDS(1024), .MAX_FRAMES(32), .ADDR_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Frame-level reference model
    int          m_len[$];
    int          m_rem[$];
    logic [31:0] m_words[$];
    int          m_drop = 0;
    bit          m_ovf  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic apb_read(input logic [15:0] a, output logic [31:0] d, output logic e);
        @(posedge clk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = a;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        @(negedge clk);
        d = bus.prdata; e = bus.pslverr;
        chk("pready_rd", 32'(bus.pready), 32'd1);
        @(posedge clk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
    endtask

    task automatic apb_write(input logic [15:0] a, input logic [31:0] v, output logic e);
        @(posedge clk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = a; bus.pwdata = v;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        @(negedge clk);
        e = bus.pslverr;
        chk("pready_wr", 32'(bus.pready), 32'd1);
        @(posedge clk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    endtask

    task automatic rd_chk(input logic [15:0] a, input logic [31:0] exp_d, input logic exp_e, input string tag);
        logic [31:0] d; logic e;
        apb_read(a, d, e);
        chk({tag, "_data"}, d, exp_d);
        chk({tag, "_err"}, 32'(e), 32'(exp_e));
    endtask

    task automatic wr_chk(input logic [15:0] a, input logic [31:0] v, input logic exp_e, input string tag);
        logic e;
        apb_write(a, v, e);
        chk({tag, "_err"}, 32'(e), 32'(exp_e));
    endtask

    task automatic stat_chk(input string tag);
        logic [31:0] exp;
        exp = {30'h0, m_ovf, (m_len.size() != 0)};
        rd_chk(A_STAT, exp, 1'b0, tag);
    endtask

    // Read n words of the head frame, each compared with the model's next word.
    task automatic read_words(input int n, input string tag);
        logic [31:0] d; logic e;
        for (int i = 0; i < n; i++) begin
            apb_read(A_RX, d, e);
            chk($sformatf("%s_w%0d", tag, i), d, m_words.pop_front());
            chk($sformatf("%s_e%0d", tag, i), 32'(e), 32'd0);
            m_rem[0] = m_rem[0] - 1;
            if (m_rem[0] == 0) begin
                void'(m_len.pop_front());
                void'(m_rem.pop_front());
            end
        end
    endtask

    task automatic read_frame(input string tag);
        rd_chk(A_LEN, 32'(m_len[0]), 1'b0, {tag, "_len"});
        read_words(m_rem[0], tag);
    endtask

    // Drive one frame of len bytes; bytes in lanes past the length carry junk.
    task automatic send_frame(input int len, input bit err, input bit nulls,
                              input bit fixed_last, input logic [31:0] last_word);
        int nw, nb, rem;
        logic [31:0] w;
        logic [3:0]  s;
        logic [31:0] fw[$];
        bit ovf_cond;
        nw = (len + 3) / 4;
        nb = (nw == 0) ? 1 : nw;
        for (int k = 0; k < nb; k++) begin
            if (nulls && k > 0 && $urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                bus.axis_tvalid = 1'b1; bus.axis_tstrb = 4'h0; bus.axis_tlast = 1'b0;
                bus.axis_tdata = $urandom; bus.axis_tuser = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk); #1;
                bus.axis_tvalid = 1'b0;
            end
            rem = len - 4 * k;
            s = (rem >= 4) ? 4'hF : (rem == 3) ? 4'h7 : (rem == 2) ? 4'h3 : (rem == 1) ? 4'h1 : 4'h0;
            w = (fixed_last && k == nb - 1) ? last_word : $urandom;
            @(posedge clk); #1;
            bus.axis_tvalid = 1'b1; bus.axis_tdata = w; bus.axis_tstrb = s;
            bus.axis_tlast  = (k == nb - 1);
            bus.axis_tuser  = (k == nb - 1) ? err : 1'($urandom_range(0, 1));
            if (s != 4'h0) fw.push_back(w & {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}});
        end
        @(posedge clk); #1;
        bus.axis_tvalid = 1'b0; bus.axis_tlast = 1'b0; bus.axis_tuser = 1'b0; bus.axis_tstrb = 4'h0;
        ovf_cond = (len > 0 && m_words.size() + nw > 1024) || (m_len.size() >= 32);
        if (ovf_cond) begin
            m_ovf = 1'b1;
            if (m_drop < 65535) m_drop++;
        end else if (err || len == 0 || len > 2047) begin
            if (m_drop < 65535) m_drop++;
        end else begin
            m_len.push_back(len);
            m_rem.push_back(nw);
            foreach (fw[i]) m_words.push_back(fw[i]);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic e;
        int la, lb;
        bus.axis_tvalid = 1'b0; bus.axis_tdata = 32'h0; bus.axis_tstrb = 4'h0;
        bus.axis_tlast = 1'b0; bus.axis_tuser = 1'b0;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 16'h0; bus.pwdata = 32'h0;
        rst = 1'b1;

        // ---- reset ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("tready_in_rst", 32'(bus.axis_tready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("tready_after_rst", 32'(bus.axis_tready), 32'd1);
        chk("prdata_idle", bus.prdata, 32'h0);
        chk("pslverr_idle", 32'(bus.pslverr), 32'd0);
        stat_chk("rst_stat");
        rd_chk(A_LEN, 32'h0, 1'b0, "rst_len");
        rd_chk(A_DROP, 32'h0, 1'b0, "rst_drop");

        // ---- 60-byte frame, STAT timing relative to tlast ----
        send_frame(60, 1'b0, 1'b0, 1'b0, 32'h0);
        bus.psel = 1'b1; bus.penable = 1'b1; bus.pwrite = 1'b0; bus.paddr = A_STAT;
        @(negedge clk);
        chk("f60_stat_n1", bus.prdata, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("f60_stat_n2", bus.prdata, 32'h1);
        @(posedge clk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
        rd_chk(A_LEN, 32'd60, 1'b0, "f60_len");
        read_words(15, "f60");
        stat_chk("f60_drained");

        // ---- 61-byte frame, last beat tstrb=0001 ----
        send_frame(61, 1'b0, 1'b0, 1'b1, 32'hAABBCCDD);
        rd_chk(A_LEN, 32'd61, 1'b0, "f61_len");
        read_words(16, "f61");

        // ---- errored frame between two good ones, then zero-byte frame ----
        la = $urandom_range(8, 120);
        lb = $urandom_range(8, 120);
        send_frame(la, 1'b0, 1'b1, 1'b0, 32'h0);
        send_frame(50, 1'b1, 1'b1, 1'b0, 32'h0);
        send_frame(lb, 1'b0, 1'b1, 1'b0, 32'h0);
        rd_chk(A_DROP, 32'(m_drop), 1'b0, "tuser_drop");
        read_frame("good_a");
        read_frame("good_b");
        send_frame(0, 1'b0, 1'b0, 1'b0, 32'h0);
        rd_chk(A_DROP, 32'(m_drop), 1'b0, "zero_drop");
        stat_chk("zero_stat");
        wr_chk(A_DROP, 32'h0, 1'b0, "clr1");
        m_drop = 0; m_ovf = 1'b0;
        rd_chk(A_DROP, 32'h0, 1'b0, "clr1_drop");

        // ---- fill data FIFO, then overflow ----
        for (int i = 0; i < 16; i++) send_frame(256, 1'b0, 1'b0, 1'b0, 32'h0);
        send_frame(64, 1'b0, 1'b0, 1'b0, 32'h0);
        stat_chk("ovf_stat");
        rd_chk(A_DROP, 32'(m_drop), 1'b0, "ovf_drop");
        wr_chk(A_DROP, $urandom, 1'b0, "clr2");
        m_drop = 0; m_ovf = 1'b0;
        stat_chk("clr2_stat");
        rd_chk(A_DROP, 32'h0, 1'b0, "clr2_drop");
        while (m_len.size() != 0) read_frame("fill");

        // ---- POP part-way through a 100-byte frame ----
        send_frame(100, 1'b0, 1'b0, 1'b0, 32'h0);
        send_frame(40, 1'b0, 1'b0, 1'b0, 32'h0);
        rd_chk(A_LEN, 32'd100, 1'b0, "pop_len0");
        read_words(2, "pop_head");
        wr_chk(A_POP, $urandom, 1'b0, "pop");
        repeat (m_rem[0]) void'(m_words.pop_front());
        void'(m_len.pop_front());
        void'(m_rem.pop_front());
        rd_chk(A_LEN, 32'd40, 1'b0, "pop_len1");
        read_words(10, "pop_next");

        // ---- random frames interleaved with reads ----
        for (int i = 0; i < 12; i++) begin
            send_frame($urandom_range(1, 300), ($urandom_range(0, 4) == 0), 1'b1, 1'b0, 32'h0);
            if ($urandom_range(0, 1) == 1 && m_len.size() != 0) read_frame($sformatf("rnd%0d", i));
        end
        while (m_len.size() != 0) read_frame("rnd_drain");
        rd_chk(A_DROP, 32'(m_drop), 1'b0, "rnd_drop");

        // ---- access errors ----
        rd_chk(A_RX, 32'h0, 1'b1, "rx_empty");
        wr_chk(A_STAT, 32'h1, 1'b1, "wr_stat");
        wr_chk(A_LEN, 32'h1, 1'b1, "wr_len");
        wr_chk(A_RX, 32'h1, 1'b1, "wr_rx");
        rd_chk(A_POP, 32'h0, 1'b1, "rd_pop");
        rd_chk(16'h0010, 32'h0, 1'b1, "rd_unmapped");
        wr_chk(16'h00A0, 32'h0, 1'b1, "wr_unmapped");
        wr_chk(A_POP, 32'h0, 1'b0, "pop_empty");
        stat_chk("pop_empty_stat");

        // ---- reset in the middle of a frame ----
        send_frame(40, 1'b0, 1'b0, 1'b0, 32'h0);
        send_frame(20, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            bus.axis_tvalid = 1'b1; bus.axis_tdata = $urandom; bus.axis_tstrb = 4'hF;
            bus.axis_tlast = 1'b0; bus.axis_tuser = 1'b0;
        end
        @(posedge clk); #1;
        bus.axis_tvalid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_len.delete(); m_rem.delete(); m_words.delete();
        m_drop = 0; m_ovf = 1'b0;
        stat_chk("mid_rst_stat");
        rd_chk(A_LEN, 32'h0, 1'b0, "mid_rst_len");
        rd_chk(A_DROP, 32'h0, 1'b0, "mid_rst_drop");
        send_frame(24, 1'b0, 1'b0, 1'b0, 32'h0);
        read_frame("post_rst");
        stat_chk("final_stat");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axis_apb_ethernet_rx_buffer.md
# axis_apb_ethernet_rx_buffer

Receive-side counterpart of the APB-to-AXI-Stream Ethernet transmit buffer. Accepts Ethernet frames from a MAC over 32-bit AXI-Stream, stores good frames in a block-RAM FIFO, and drops errored or overflowing frames by rolling back the write pointer. Software drains frames word-by-word over a 32-bit APB completer. Single clock domain; the MAC RX stream must already be in that domain.

## Interface
- DEPTH_WORDS, 1024: data FIFO depth in 32-bit words (power of 2).
- MAX_FRAMES, 32: length FIFO depth (power of 2).
- ADDR_WIDTH, 16: APB address width.

- clk  in  1  sole clock; APB pclk and AXIS aclk.
- rst  in  1  synchronous, active-high reset.
- axis_tvalid  in  1  RX beat valid.
- axis_tready  out  1  always 1 except during rst; overflow is handled by dropping, never by backpressure.
- axis_tdata  in  32  RX data, byte 0 in [7:0].
- axis_tstrb  in  4  valid byte lanes, contiguous from lane 0.
- axis_tlast  in  1  last beat of frame.
- axis_tuser  in  1  frame error (FCS/PHY); sampled on the tlast beat.
- psel, penable, pwrite  in  1 each  APB control.
- paddr  in  ADDR_WIDTH  APB address.
- pwdata  in  32  APB write data.
- pready  out  1  psel && penable, combinational; no wait states.
- prdata  out  32  read data; 0 unless a valid read is in its access phase.
- pslverr  out  1  error response, same cycle as pready.

## Operation
- Register map:
  - 0x00 STAT (RO): [0] frame_avail, [1] overflow sticky.
  - 0x20 LENGTH (RO): head frame length in bytes, [10:0]; 0 if none.
  - 0x40 RX_WORD (RO): returns the next word of the head frame and advances.
  - 0x60 POP (WO): any value discards the rest of the head frame.
  - 0x80 DROP_COUNT: RW. Read [15:0] returns the count of dropped frames. A write clears the count and the overflow flag.
- Access errors:
  - Writes to a RO register assert pslverr. So does a read of POP, or any unmapped address.
  - RX_WORD read with frame_avail=0 returns 0 and asserts pslverr.
- Write side:
  - Beat with tstrb≠0 is stored at wr_ptr; lanes not in tstrb are written as 0.
  - frame_bytes accumulates popcount(tstrb) in 12 bits. Beats with tstrb=0 are not stored; a tlast beat still ends the frame.
  - Frame marked bad on any of:
    - data FIFO full (wr_ptr − rd_ptr == DEPTH_WORDS) when a word must be stored;
    - length FIFO full at tlast;
    - frame_bytes > 2047;
    - tuser=1 on tlast.
  - Once bad, the remaining beats of the frame are discarded.
  - tlast on a good frame: push frame_bytes[10:0] to the length FIFO and set commit_ptr to the post-beat wr_ptr.
  - tlast on a bad frame: set wr_ptr to commit_ptr and increment drop_count, saturating at 0xFFFF.
  - Overflow causes additionally set the overflow flag.
  - A zero-byte good frame is dropped and counted.
- Read side:
  - prefetch register holds mem[rd_ptr].
  - words_left = ceil(head_len/4), loaded when the head frame is presented.
  - frame_avail = length FIFO nonempty && prefetch_valid.
  - RX_WORD read: return the prefetch, rd_ptr+1, words_left−1, invalidate the prefetch. A refetch is issued on the next cycle. When words_left reaches 0, the length FIFO pops.
  - POP: rd_ptr += words_left, pop the length FIFO, invalidate the prefetch. No effect if no frame is present.
  - A prefetch is only issued while the length FIFO is nonempty. Uncommitted data is never read.

## Timing
- Reset values:
  - Pointers 0, both FIFOs empty, drop_count 0, overflow 0.
  - prefetch_valid 0; axis_tready 0 during rst, 1 on the first cycle after.
  - prdata/pslverr 0.
- tlast beat of a good frame accepted at cycle N:
  - length entry is visible at N+1;
  - prefetch RAM read at N+1, data registered at N+2;
  - STAT[0]=1 and LENGTH valid from N+2.
- After an RX_WORD access at cycle M, the prefetch is valid again at M+2. The next APB access phase is ≥M+2, so back-to-back reads never stall.
- Commit and pop in the same cycle: the length FIFO count is unchanged. Both operations take effect.
- Bad-frame rollback takes effect on the tlast cycle. A new frame may start on the next beat.
- The full check uses the current rd_ptr, including a pop in the same cycle.
- Reset mid-frame discards all stored and partial frames. drop_count is not incremented.

## Test plan
- 60-byte good frame (15 full beats, tuser=0) -> STAT=1 two cycles after tlast, LENGTH=60, 15 RX_WORD reads return data in order, then STAT[0]=0.
- 61-byte frame (last tstrb=0001, tdata=0xAABBCCDD) -> LENGTH=61, 16th word reads 0x000000DD.
- Frame with tuser=1 on tlast between two good frames -> DROP_COUNT=1, the two good frames are read back intact and contiguous.
- 1024 words of committed frames unread, then a further 64-byte frame -> frame dropped, STAT[1]=1, DROP_COUNT=1; writing DROP_COUNT clears both.
- Read 2 words of a 100-byte frame, write POP -> LENGTH shows the next frame, and its first RX_WORD is that frame's word 0.
- RX_WORD read with no frame -> prdata=0, pslverr=1; write to STAT -> pslverr=1; assert rst during a frame -> STAT=0, LENGTH=0.
